// File: rtl/led_pkg.sv
// Shared brightness width default and level helpers for the LED PWM dimmer.
package led_pkg;
    localparam int LEVEL_W_DEF = 3;

    typedef logic [LEVEL_W_DEF-1:0] level_t;

    function automatic int max_level(input int w);
        return (1 << w) - 1;
    endfunction
endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: edge-detected up/down requests, saturating target,
// period-aligned displayed level and the registered PWM comparator.
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int LEVEL_W = LEVEL_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bright_up,
    input  logic               bright_down,
    input  logic               fade_en,
    input  logic               period_end,
    input  logic [LEVEL_W-1:0] pwm_cnt,
    output logic [LEVEL_W-1:0] level,
    output logic               led
);
    localparam logic [LEVEL_W-1:0] MAX_L = LEVEL_W'(max_level(LEVEL_W));
    localparam logic [LEVEL_W-1:0] ONE   = LEVEL_W'(1);

    logic               up_q, dn_q, led_q;
    logic               up_evt, dn_evt;
    logic [LEVEL_W-1:0] target_q, target_d;
    logic [LEVEL_W-1:0] level_q, level_d;

    always_comb begin
        up_evt   = bright_up & ~up_q;
        dn_evt   = bright_down & ~dn_q;
        target_d = target_q;
        if (up_evt && !dn_evt && target_q != MAX_L)
            target_d = target_q + ONE;
        else if (dn_evt && !up_evt && target_q != '0)
            target_d = target_q - ONE;

        // Level only moves at the period boundary so no PWM period is ever cut short.
        level_d = level_q;
        if (period_end) begin
            if (!fade_en)
                level_d = target_q;
            else if (level_q < target_q)
                level_d = level_q + ONE;
            else if (level_q > target_q)
                level_d = level_q - ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_q     <= 1'b0;
            dn_q     <= 1'b0;
            target_q <= '0;
            level_q  <= '0;
            led_q    <= 1'b0;
        end else begin
            up_q     <= bright_up;
            dn_q     <= bright_down;
            target_q <= target_d;
            level_q  <= level_d;
            led_q    <= (pwm_cnt < level_q);
        end
    end

    assign level = level_q;
    assign led   = led_q;
endmodule

// File: rtl/led_pwm_dimmer.sv
// Multi-channel LED dimmer: shared prescaler and PWM counter feeding
// N_CH independent brightness channels.
module led_pwm_dimmer
    import led_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int LEVEL_W  = LEVEL_W_DEF,
    parameter int PRESCALE = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_CH-1:0]           bright_up,
    input  logic [N_CH-1:0]           bright_down,
    input  logic                      fade_en,
    output logic [N_CH-1:0]           led,
    output logic [N_CH*LEVEL_W-1:0]   level,
    output logic                      period_end
);
    localparam int                 PRESC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [LEVEL_W-1:0] CNT_LAST   = LEVEL_W'(max_level(LEVEL_W) - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [LEVEL_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic               tick, cnt_last, pe;

    always_comb begin
        tick      = (presc_q == PRESC_LAST);
        cnt_last  = (pwm_cnt_q == CNT_LAST);
        pe        = tick & cnt_last;
        presc_d   = tick ? '0 : presc_q + PRESC_W'(1);
        pwm_cnt_d = pwm_cnt_q;
        if (tick)
            pwm_cnt_d = cnt_last ? '0 : pwm_cnt_q + LEVEL_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    // Gated so the pulse is held low for the whole reset, whatever PRESCALE is.
    assign period_end = pe & ~reset;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        led_pwm_channel #(
            .LEVEL_W (LEVEL_W)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .bright_up   (bright_up[i]),
            .bright_down (bright_down[i]),
            .fade_en     (fade_en),
            .period_end  (pe),
            .pwm_cnt     (pwm_cnt_q),
            .level       (level[i*LEVEL_W +: LEVEL_W]),
            .led         (led[i])
        );
    end
endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Self-checking bench for led_pwm_dimmer: cycle scoreboard fed by a reference
// model, a table of pulse records, and hand-written reset/fade sequences.
module tb_led_pwm_dimmer;
    localparam int N_CH     = 2;
    localparam int LEVEL_W  = 3;
    localparam int PRESCALE = 1;
    localparam int MAXL     = 7;

    logic                    clk;
    logic                    rst;
    logic [N_CH-1:0]         bright_up;
    logic [N_CH-1:0]         bright_down;
    logic                    fade_en;
    logic [N_CH-1:0]         led;
    logic [N_CH*LEVEL_W-1:0] level;
    logic                    period_end;

    int n_checks = 0;
    int n_err    = 0;

    led_pwm_dimmer #(
        .N_CH     (N_CH),
        .LEVEL_W  (LEVEL_W),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk         (clk),
        .reset       (rst),
        .bright_up   (bright_up),
        .bright_down (bright_down),
        .fade_en     (fade_en),
        .led         (led),
        .level       (level),
        .period_end  (period_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] led;
        logic [5:0] level;
        logic       pe;
    } exp_t;

    exp_t sb_q[$];

    int m_presc, m_cnt;
    int m_tgt[2];
    int m_lvl[2];
    bit m_led[2];
    bit m_upq[2];
    bit m_dnq[2];

    // Reference model: advances on every clock and queues the outputs it predicts.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_presc = 0;
            m_cnt   = 0;
            for (int c = 0; c < 2; c++) begin
                m_tgt[c] = 0; m_lvl[c] = 0; m_led[c] = 0; m_upq[c] = 0; m_dnq[c] = 0;
            end
            sb_q.delete();
        end else begin
            bit   pe_now, u, d;
            exp_t e;
            pe_now = (m_presc == PRESCALE - 1) && (m_cnt == MAXL - 1);
            for (int c = 0; c < 2; c++) begin
                m_led[c] = (m_cnt < m_lvl[c]);
                if (pe_now) begin
                    if (!fade_en)                m_lvl[c] = m_tgt[c];
                    else if (m_lvl[c] < m_tgt[c]) m_lvl[c] = m_lvl[c] + 1;
                    else if (m_lvl[c] > m_tgt[c]) m_lvl[c] = m_lvl[c] - 1;
                end
                u = bright_up[c] && !m_upq[c];
                d = bright_down[c] && !m_dnq[c];
                if (u && !d && m_tgt[c] < MAXL)     m_tgt[c] = m_tgt[c] + 1;
                else if (d && !u && m_tgt[c] > 0)   m_tgt[c] = m_tgt[c] - 1;
                m_upq[c] = bright_up[c];
                m_dnq[c] = bright_down[c];
            end
            if (m_presc == PRESCALE - 1) begin
                m_presc = 0;
                m_cnt   = (m_cnt == MAXL - 1) ? 0 : m_cnt + 1;
            end else begin
                m_presc = m_presc + 1;
            end
            e.led   = {m_led[1], m_led[0]};
            e.level = {3'(m_lvl[1]), 3'(m_lvl[0])};
            e.pe    = (m_presc == PRESCALE - 1) && (m_cnt == MAXL - 1);
            sb_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            if ({led, level, period_end} !== e) begin
                n_err++;
                $display("FAIL scoreboard t=%0t got led=%b level=%o pe=%b, want led=%b level=%o pe=%b",
                         $time, led, level, period_end, e.led, e.level, e.pe);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_pe();
        bit seen;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (period_end) seen = 1;
        end
        if (!seen) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_pe: no period_end within 20 clks");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic duty(input int ch, output int n);
        n = 0;
        repeat (MAXL) begin
            @(negedge clk);
            if (led[ch]) n++;
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] up;
        logic [1:0] dn;
        int         pulses;
        int         exp_l0;
        int         exp_l1;
        int         exp_duty0;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int d;
        int n_pe;

        vecs[0] = '{2'b01, 2'b00, 9, 7, 0, 7};  // ch0 saturates high
        vecs[1] = '{2'b00, 2'b01, 9, 0, 0, 0};  // ch0 saturates low
        vecs[2] = '{2'b10, 2'b00, 2, 0, 2, 0};
        vecs[3] = '{2'b11, 2'b10, 3, 3, 2, 3};  // ch1 up+down together: no change
        vecs[4] = '{2'b00, 2'b10, 2, 3, 0, 3};
        vecs[5] = '{2'b00, 2'b01, 3, 0, 0, 0};

        rst         = 1'b1;
        bright_up   = '0;
        bright_down = '0;
        fade_en     = 1'b0;

        @(negedge clk);
        check("reset_led", int'(led), 0);
        check("reset_level", int'(level), 0);
        check("reset_pe", int'(period_end), 0);
        cyc(1);
        rst = 1'b0;

        n_pe = 0;
        repeat (21) begin
            @(negedge clk);
            if (period_end) n_pe++;
        end
        check("idle_pe_count", n_pe, 3);
        check("idle_led", int'(led), 0);
        check("idle_level", int'(level), 0);
        cyc(1);

        bright_up = 2'b01;
        cyc(30);
        check("held_up_level0", int'(level[2:0]), 1);
        bright_up = 2'b00;
        cyc(1);
        duty(0, d);
        check("held_up_duty0", d, 1);

        for (int i = 0; i < 6; i++) begin
            repeat (vecs[i].pulses) begin
                bright_up   = vecs[i].up;
                bright_down = vecs[i].dn;
                cyc(1);
                bright_up   = '0;
                bright_down = '0;
                cyc(1);
            end
            wait_pe();
            wait_pe();
            check($sformatf("vec%0d_level0", i), int'(level[2:0]), vecs[i].exp_l0);
            check($sformatf("vec%0d_level1", i), int'(level[5:3]), vecs[i].exp_l1);
            duty(0, d);
            check($sformatf("vec%0d_duty0", i), d, vecs[i].exp_duty0);
        end

        fade_en = 1'b1;
        wait_pe();
        repeat (5) begin
            bright_up = 2'b01;
            cyc(1);
            bright_up = 2'b00;
            cyc(1);
        end
        check("fade_step1", int'(level[2:0]), 1);
        for (int s = 2; s <= 5; s++) begin
            wait_pe();
            check($sformatf("fade_step%0d", s), int'(level[2:0]), s);
        end

        repeat (2) begin
            bright_up = 2'b01;
            cyc(1);
            bright_up = 2'b00;
            cyc(1);
        end
        check("prefade_level0", int'(level[2:0]), 5);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_led", int'(led), 0);
        check("async_rst_level", int'(level), 0);
        check("async_rst_pe", int'(period_end), 0);
        cyc(2);
        rst = 1'b0;
        cyc(25);
        check("post_rst_level0", int'(level[2:0]), 0);
        check("post_rst_led", int'(led), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule
